// File: rtl/nway_min_pipe.sv
// nway_min_pipe: pipelined masked N-input minimum with argmin and saturating offset add.
module nway_min_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN = 4,
  parameter int OFFSET = 1,
  parameter int IDX_W = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_mask,
  input  logic                         in_add_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_min,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_none
);
  localparam int NN = NUM_IN - 1;
  // Tree nodes are numbered heap-style: node m takes children 2m and 2m+1, where
  // children below NUM_IN are input lanes and the rest are earlier nodes (2m-NUM_IN).
  logic [DATA_WIDTH-1:0] v_q [NN];
  logic [DATA_WIDTH-1:0] v_d [NN];
  logic [IDX_W-1:0]      i_q [NN];
  logic [IDX_W-1:0]      i_d [NN];
  logic                  l_q [NN];
  logic                  l_d [NN];
  logic [IDX_W-1:0]      vld_q, vld_d, add_q, add_d;
  logic                  out_valid_q, out_valid_d, out_none_q, out_none_d;
  logic [DATA_WIDTH-1:0] out_min_q, out_min_d;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;
  logic [DATA_WIDTH:0]   sum;
  logic                  adv;
  assign adv = !out_valid_q | out_ready;
  assign in_ready = adv;
  for (genvar m = 0; m < NN; m++) begin : g_node
    logic [DATA_WIDTH-1:0] av, bv;
    logic [IDX_W-1:0]      ai, bi;
    logic                  al, bl, sa, sb;
    if (2*m < NUM_IN) begin : g_leaf
      assign av = in_data[2*m*DATA_WIDTH +: DATA_WIDTH];
      assign bv = in_data[(2*m+1)*DATA_WIDTH +: DATA_WIDTH];
      assign ai = IDX_W'(2*m);
      assign bi = IDX_W'(2*m+1);
      assign al = in_mask[2*m];
      assign bl = in_mask[2*m+1];
    end else begin : g_inner
      assign av = v_q[2*m-NUM_IN];
      assign bv = v_q[2*m-NUM_IN+1];
      assign ai = i_q[2*m-NUM_IN];
      assign bi = i_q[2*m-NUM_IN+1];
      assign al = l_q[2*m-NUM_IN];
      assign bl = l_q[2*m-NUM_IN+1];
    end
    assign sa = al & (!bl | av <= bv);
    assign sb = !sa & bl;
    assign v_d[m] = sb ? bv : av;
    assign i_d[m] = sb ? bi : ai;
    assign l_d[m] = al | bl;
  end
  assign vld_d = IDX_W'({vld_q, in_valid});
  assign add_d = IDX_W'({add_q, in_add_en});
  assign sum = {1'b0, v_q[NN-1]} + (DATA_WIDTH+1)'(OFFSET);
  always_comb begin
    out_valid_d = vld_q[IDX_W-1];
    out_none_d  = !l_q[NN-1];
    out_idx_d   = l_q[NN-1] ? i_q[NN-1] : '0;
    out_min_d   = !l_q[NN-1] ? '1 : !add_q[IDX_W-1] ? v_q[NN-1] : sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      add_q       <= '0;
      out_valid_q <= 1'b0;
      out_none_q  <= 1'b0;
      out_idx_q   <= '0;
      out_min_q   <= '0;
    end else if (adv) begin
      vld_q       <= vld_d;
      add_q       <= add_d;
      v_q         <= v_d;
      i_q         <= i_d;
      l_q         <= l_d;
      out_valid_q <= out_valid_d;
      out_none_q  <= out_none_d;
      out_idx_q   <= out_idx_d;
      out_min_q   <= out_min_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_none  = out_none_q;
  assign out_idx   = out_idx_q;
  assign out_min   = out_min_q;
endmodule

// File: tb/tb_nway_min_pipe.sv
// tb_nway_min_pipe: scoreboard bench for nway_min_pipe at NUM_IN = 4, 16 and 2.
module tb_nway_min_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [127:0] data = '0;
  logic [15:0]  mask = '0;
  logic         add_en = 1'b0, vin = 1'b0, ordy = 1'b0;
  int           sel = 0;
  logic         r4, r16, r2, v4, v16, v2, n4, n16, n2;
  logic [7:0]   m4, m16, m2;
  logic [1:0]   i4;
  logic [3:0]   i16;
  logic [0:0]   i2;
  nway_min_pipe #(.NUM_IN(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(vin && sel == 0), .in_ready(r4),
    .in_data(data[31:0]), .in_mask(mask[3:0]), .in_add_en(add_en),
    .out_valid(v4), .out_ready(ordy), .out_min(m4), .out_idx(i4), .out_none(n4));
  nway_min_pipe #(.NUM_IN(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(vin && sel == 1), .in_ready(r16),
    .in_data(data), .in_mask(mask), .in_add_en(add_en),
    .out_valid(v16), .out_ready(ordy), .out_min(m16), .out_idx(i16), .out_none(n16));
  nway_min_pipe #(.NUM_IN(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(vin && sel == 2), .in_ready(r2),
    .in_data(data[15:0]), .in_mask(mask[1:0]), .in_add_en(add_en),
    .out_valid(v2), .out_ready(ordy), .out_min(m2), .out_idx(i2), .out_none(n2));
  logic       rdy, ov, onone;
  logic [7:0] omin;
  logic [3:0] oidx;
  int         n;
  always_comb begin
    rdy   = sel == 0 ? r4 : sel == 1 ? r16 : r2;
    ov    = sel == 0 ? v4 : sel == 1 ? v16 : v2;
    onone = sel == 0 ? n4 : sel == 1 ? n16 : n2;
    omin  = sel == 0 ? m4 : sel == 1 ? m16 : m2;
    oidx  = sel == 0 ? {2'b0, i4} : sel == 1 ? i16 : {3'b0, i2};
    n     = sel == 0 ? 4 : sel == 1 ? 16 : 2;
  end
  int          n_asrt = 0, n_fail = 0;
  logic [12:0] q[$];
  logic [12:0] prev = '0;
  bit          prev_st = 0, acc = 0;
  // Expected {none, idx, min}: lowest-index live lane holding the smallest value.
  function automatic logic [12:0] model(input logic [127:0] d, input logic [15:0] m, input int nn, input bit a);
    bit         f = 0;
    logic [7:0] bv = '0;
    logic [3:0] bi = '0;
    logic [8:0] s;
    for (int i = 0; i < nn; i++)
      if (m[i] && (!f || d[i*8 +: 8] < bv)) begin
        f = 1;
        bv = d[i*8 +: 8];
        bi = 4'(i);
      end
    s = {1'b0, bv} + 9'd1;
    if (!f) return {1'b1, 4'd0, 8'hFF};
    return {1'b0, bi, a ? (s[8] ? 8'hFF : s[7:0]) : bv};
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input bit v, input logic [127:0] d, input logic [15:0] m, input bit a, input bit r,
                     input logic [13:0] e = 14'd0);
    @(negedge clk);
    vin = v; data = d; mask = m; add_en = a; ordy = r;
    #1;
    if (prev_st) chk("stall_hold", {3'b0, ov, onone, oidx, omin}, {3'b0, 1'b1, prev});
    if (ov && ordy) begin
      chk("out_expected", 16'(q.size() != 0), 16'd1);
      if (q.size() != 0) chk("result", {3'b0, onone, oidx, omin}, {3'b0, q.pop_front()});
    end
    prev_st = ov && !ordy;
    prev = {onone, oidx, omin};
    acc = vin && rdy;
    if (acc) q.push_back(e[13] ? e[12:0] : model(d, m, n, a));
  endtask
  task automatic rst();
    @(negedge clk);
    reset = 1'b1;
    vin = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    prev_st = 0;
  endtask
  task automatic rnd(output logic [127:0] d, output logic [15:0] m, output bit a);
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(0, 20));
    m = $urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom);
    a = 1'($urandom);
  endtask
  task automatic stream(input int s);
    logic [127:0] d;
    logic [15:0]  m;
    bit           a;
    int           cnt, sent, guard;
    sel = s;
    cnt = 0;
    // With out_ready low the pipe fills to its depth, then in_ready drops.
    for (int i = 0; i < n + 4 && i < 12; i++) begin
      rnd(d, m, a);
      cyc(1, d, m, a, 0);
      if (acc) cnt++;
    end
    chk("fill_count", 16'(cnt), 16'($clog2(n) + 1));
    chk("full_ready", 16'(rdy), 16'd0);
    sent = 0;
    guard = 0;
    rnd(d, m, a);
    while ((sent < 8 || q.size() != 0) && guard < 300) begin
      cyc(sent < 8, d, m, a, 1'($urandom));
      if (acc) begin
        sent++;
        rnd(d, m, a);
      end
      guard++;
    end
    chk("stream_done", 16'(guard < 300), 16'd1);
    cyc(0, '0, '0, 0, 1);
    chk("stream_idle", 16'(ov), 16'd0);
  endtask
  initial begin
    logic [127:0] d;
    logic [15:0]  m;
    bit           a;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_u4", 16'({v4, n4, i4, m4}), 16'd0);
    chk("rst_ready", 16'(r4), 16'd1);
    chk("rst_u16", 16'({v16, n16, i16, m16}), 16'd0);
    chk("rst_u2", 16'({v2, n2, i2, m2}), 16'd0);
    sel = 0;
    rnd(d, m, a);
    cyc(1, d, 16'hF, a, 1);
    cyc(1, d, 16'hF, a, 1);
    rst();
    for (int k = 0; k < 6; k++) begin
      cyc(0, '0, '0, 0, 1);
      chk("no_ghost", 16'(ov), 16'd0);
    end
    cyc(1, 128'h05_07_03_09, 16'hF, 0, 1, {1'b1, 1'b0, 4'd1, 8'd3});
    for (int k = 1; k <= 3; k++) begin
      cyc(0, '0, '0, 0, 1);
      chk("latency", 16'(ov), 16'(k == 3));
    end
    cyc(1, 128'h02_02_02_06, 16'hF, 1, 1, {1'b1, 1'b0, 4'd1, 8'd3});
    cyc(1, 128'hFF_FF_FF_FF, 16'hF, 1, 1, {1'b1, 1'b0, 4'd0, 8'hFF});
    cyc(1, 128'hFF_FF_FF_FF, 16'h0, 1, 1, {1'b1, 1'b1, 4'd0, 8'hFF});
    cyc(1, 128'h08_00_04_01, 16'hA, 0, 1, {1'b1, 1'b0, 4'd1, 8'd4});
    repeat (5) cyc(0, '0, '0, 0, 1);
    chk("directed_drained", 16'(q.size()), 16'd0);
    stream(0);
    stream(1);
    stream(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
